// File: rtl/gpio_bank_pkg.sv
// Shared definitions for the GPIO bank: per-port register offsets, the unmapped
// read value and the address-to-port decode helper.
package gpio_bank_pkg;

  typedef enum logic [2:0] {
    REG_DDR  = 3'd0,
    REG_PORT = 3'd1,
    REG_PIN  = 3'd2,
    REG_SP   = 3'd3,
    REG_IEN  = 3'd4,
    REG_IEDG = 3'd5,
    REG_IFLG = 3'd6,
    REG_TGL  = 3'd7
  } reg_off_e;

  localparam logic [7:0] UNMAPPED_RD = 8'hAA;

  // Each port owns eight consecutive addresses, so the port index is addr / 8.
  function automatic int unsigned port_sel(input logic [15:0] a);
    return 32'(a >> 3);
  endfunction

endpackage

// File: rtl/gpio_bank_if.sv
// Internal 8-bit peripheral bus as seen by the GPIO bank.
interface gpio_bank_if #(
  parameter int AW = 6
);
  logic [AW-1:0] addr;
  logic [7:0]    data_in;
  logic [7:0]    data_out;
  logic          bus_cyc;
  logic          bus_we;

  modport master (output addr, data_in, bus_cyc, bus_we, input data_out);
  modport slave  (input addr, data_in, bus_cyc, bus_we, output data_out);
endinterface

// File: rtl/gpio_port8.sv
// One 8-pin GPIO port: registers, input synchroniser, edge-triggered flags and
// the pad multiplexers between software GPIO and the special-function peripheral.
module gpio_port8
  import gpio_bank_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       wb_clk_i,
  input  logic       rst,
  input  logic       we,
  input  reg_off_e   offset,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  input  logic [7:0] io_in,
  output logic [7:0] io_out,
  output logic [7:0] io_oeb,
  input  logic [7:0] sf_out,
  input  logic [7:0] sf_oe,
  output logic [7:0] sf_in,
  output logic       irq
);

  logic [7:0] ddr_q, port_q, sp_q, ien_q, iedg_q, iflg_q;
  logic [SYNC_STAGES-1:0][7:0] sync_q;
  logic [7:0] hist_q;
  logic [7:0] pin;
  logic [7:0] iedg_eff, w1c, edge_seen, iflg_next;

  assign pin = sync_q[SYNC_STAGES-1];

  // An IEDG write lands in the same cycle as the edge it qualifies.
  always_comb begin
    // NOTE: every output of a comb block gets a default first so no latch is inferred.
    iedg_eff  = iedg_q;
    w1c       = 8'h00;
    if (we && offset == REG_IEDG) iedg_eff = wdata;
    if (we && offset == REG_IFLG) w1c      = wdata;
    edge_seen = ((pin & ~hist_q) & ~iedg_eff) | ((~pin & hist_q) & iedg_eff);
    iflg_next = (iflg_q & ~w1c) | (edge_seen & ien_q);
  end

  always_ff @(posedge wb_clk_i) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      ddr_q  <= '0;
      port_q <= '0;
      sp_q   <= '0;
      ien_q  <= '0;
      iedg_q <= '0;
      iflg_q <= '0;
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      if (we) begin
        unique case (offset)
          REG_DDR:  ddr_q  <= wdata;
          REG_PORT: port_q <= wdata;
          REG_SP:   sp_q   <= wdata;
          REG_IEN:  ien_q  <= wdata;
          REG_IEDG: iedg_q <= wdata;
          REG_TGL:  port_q <= port_q ^ wdata;
          default:  ;
        endcase
      end
      iflg_q <= iflg_next;
      sync_q <= {sync_q[SYNC_STAGES-2:0], io_in};
      hist_q <= pin;
    end
  end

  always_comb begin
    rdata = 8'h00;
    unique case (offset)
      REG_DDR:  rdata = ddr_q;
      REG_PORT: rdata = port_q;
      REG_PIN:  rdata = pin;
      REG_SP:   rdata = sp_q;
      REG_IEN:  rdata = ien_q;
      REG_IEDG: rdata = iedg_q;
      REG_IFLG: rdata = iflg_q;
      default:  rdata = 8'h00;
    endcase
  end

  assign io_out = (sp_q & sf_out) | (~sp_q & port_q);
  assign io_oeb = (sp_q & ~sf_oe) | (~sp_q & ~ddr_q);
  assign sf_in  = sp_q & io_in;
  assign irq    = |(iflg_q & ien_q);

endmodule

// File: rtl/gpio_bank.sv
// NPORTS-port GPIO bank: address decode across the port instances and the
// registered bus read path.
module gpio_bank
  import gpio_bank_pkg::*;
#(
  parameter int NPORTS      = 2,
  parameter int SYNC_STAGES = 2,
  parameter int AW          = 6
) (
  input  logic                wb_clk_i,
  input  logic                rst,
  gpio_bank_if.slave          bus,
  input  logic [NPORTS*8-1:0] io_in,
  output logic [NPORTS*8-1:0] io_out,
  output logic [NPORTS*8-1:0] io_oeb,
  input  logic [NPORTS*8-1:0] sf_out,
  input  logic [NPORTS*8-1:0] sf_oe,
  output logic [NPORTS*8-1:0] sf_in,
  output logic [NPORTS-1:0]   irq
);

  localparam logic [AW:0] NREGS = (AW+1)'(NPORTS * 8);

  logic        mapped;
  int unsigned port_idx;
  logic [7:0]  port_rdata [NPORTS];
  logic [7:0]  rd_next;
  reg_off_e    offset;

  assign mapped   = {1'b0, bus.addr} < NREGS;
  assign port_idx = port_sel(16'(bus.addr));
  assign offset   = reg_off_e'(bus.addr[2:0]);

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    gpio_port8 #(.SYNC_STAGES(SYNC_STAGES)) u_port (
      .wb_clk_i (wb_clk_i),
      .rst      (rst),
      .we       (bus.bus_cyc && bus.bus_we && mapped && port_idx == unsigned'(p)),
      .offset   (offset),
      .wdata    (bus.data_in),
      .rdata    (port_rdata[p]),
      .io_in    (io_in[p*8 +: 8]),
      .io_out   (io_out[p*8 +: 8]),
      .io_oeb   (io_oeb[p*8 +: 8]),
      .sf_out   (sf_out[p*8 +: 8]),
      .sf_oe    (sf_oe[p*8 +: 8]),
      .sf_in    (sf_in[p*8 +: 8]),
      .irq      (irq[p])
    );
  end

  always_comb begin
    rd_next = UNMAPPED_RD;
    if (mapped) begin
      for (int p = 0; p < NPORTS; p++) begin
        if (port_idx == unsigned'(p)) rd_next = port_rdata[p];
      end
    end
  end

  // Read data captures the pre-write value and holds between accesses.
  always_ff @(posedge wb_clk_i) begin
    if (rst)              bus.data_out <= 8'h00;
    else if (bus.bus_cyc) bus.data_out <= rd_next;
  end

endmodule

// File: tb/tb_gpio_bank.sv
// Directed plus randomized checks of gpio_bank against a delay-line / register-array model.
module tb_gpio_bank;
  localparam int NPORTS = 2;
  localparam int SS     = 2;
  localparam int AW     = 6;
  localparam int NP8    = NPORTS * 8;

  logic            wb_clk_i = 1'b0;
  logic            rst;
  logic [NP8-1:0]  io_in, sf_out, sf_oe;
  wire  [NP8-1:0]  io_out, io_oeb, sf_in;
  wire  [NPORTS-1:0] irq;

  gpio_bank_if #(.AW(AW)) bus ();

  gpio_bank #(.NPORTS(NPORTS), .SYNC_STAGES(SS), .AW(AW)) dut (
    .wb_clk_i (wb_clk_i),
    .rst      (rst),
    .bus      (bus),
    .io_in    (io_in),
    .io_out   (io_out),
    .io_oeb   (io_oeb),
    .sf_out   (sf_out),
    .sf_oe    (sf_oe),
    .sf_in    (sf_in),
    .irq      (irq)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Reference model: register arrays plus a history of pad samples, one per edge.
  logic [7:0]     m_ddr [NPORTS], m_port [NPORTS], m_sp [NPORTS];
  logic [7:0]     m_ien [NPORTS], m_iedg [NPORTS], m_iflg [NPORTS];
  logic [7:0]     m_dout;
  logic [NP8-1:0] samp [SS+1];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_read(input int a);
    int p;
    if (a >= NP8) return 8'hAA;
    p = a / 8;
    case (a % 8)
      0: return m_ddr[p];
      1: return m_port[p];
      2: return samp[SS-1][p*8 +: 8];
      3: return m_sp[p];
      4: return m_ien[p];
      5: return m_iedg[p];
      6: return m_iflg[p];
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_edge();
    logic [NP8-1:0] pin_c, hst;
    logic [7:0] w1c [NPORTS];
    logic [7:0] ien_old [NPORTS];
    int a, p, b;
    if (rst) begin
      for (int q = 0; q < NPORTS; q++) begin
        m_ddr[q] = 0; m_port[q] = 0; m_sp[q] = 0;
        m_ien[q] = 0; m_iedg[q] = 0; m_iflg[q] = 0;
      end
      for (int k = 0; k <= SS; k++) samp[k] = '0;
      m_dout = 8'h00;
      return;
    end
    pin_c = samp[SS-1];
    hst   = samp[SS];
    for (int q = 0; q < NPORTS; q++) begin
      w1c[q] = 8'h00;
      ien_old[q] = m_ien[q];
    end
    a = int'(bus.addr);
    if (bus.bus_cyc) begin
      m_dout = m_read(a);
      if (bus.bus_we && a < NP8) begin
        p = a / 8;
        case (a % 8)
          0: m_ddr[p]  = bus.data_in;
          1: m_port[p] = bus.data_in;
          3: m_sp[p]   = bus.data_in;
          4: m_ien[p]  = bus.data_in;
          5: m_iedg[p] = bus.data_in;
          6: w1c[p]    = bus.data_in;
          7: m_port[p] = m_port[p] ^ bus.data_in;
          default: ;
        endcase
      end
    end
    for (int q = 0; q < NPORTS; q++) begin
      logic [7:0] set;
      set = 8'h00;
      for (int i = 0; i < 8; i++) begin
        b = q * 8 + i;
        if (ien_old[q][i] && ((!m_iedg[q][i] && pin_c[b] && !hst[b]) ||
                              ( m_iedg[q][i] && !pin_c[b] && hst[b])))
          set[i] = 1'b1;
      end
      m_iflg[q] = (m_iflg[q] & ~w1c[q]) | set;
    end
    for (int k = SS; k >= 1; k--) samp[k] = samp[k-1];
    samp[0] = io_in;
  endtask

  task automatic check_all();
    logic [NP8-1:0] e_out, e_oeb, e_sfin;
    logic [NPORTS-1:0] e_irq;
    for (int q = 0; q < NPORTS; q++) begin
      for (int i = 0; i < 8; i++) begin
        e_out[q*8+i]  = m_sp[q][i] ? sf_out[q*8+i] : m_port[q][i];
        e_oeb[q*8+i]  = m_sp[q][i] ? ~sf_oe[q*8+i] : ~m_ddr[q][i];
        e_sfin[q*8+i] = m_sp[q][i] ? io_in[q*8+i] : 1'b0;
      end
      e_irq[q] = |(m_iflg[q] & m_ien[q]);
    end
    check("data_out", 32'(bus.data_out), 32'(m_dout));
    check("io_out",   32'(io_out),       32'(e_out));
    check("io_oeb",   32'(io_oeb),       32'(e_oeb));
    check("sf_in",    32'(sf_in),        32'(e_sfin));
    check("irq",      32'(irq),          32'(e_irq));
  endtask

  task automatic step();
    model_edge();
    @(posedge wb_clk_i);
    #1;
    check_all();
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    bus.bus_cyc = 1'b1; bus.bus_we = 1'b1; bus.addr = AW'(a); bus.data_in = d;
    step();
    bus.bus_cyc = 1'b0; bus.bus_we = 1'b0;
  endtask

  task automatic rd(input int a);
    bus.bus_cyc = 1'b1; bus.bus_we = 1'b0; bus.addr = AW'(a);
    step();
    bus.bus_cyc = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.bus_cyc = 1'b0; bus.bus_we = 1'b0; bus.addr = '0; bus.data_in = '0;
    io_in = '0; sf_out = '0; sf_oe = '0;

    step(); step();
    rst = 1'b0;
    step();
    check("reset_oeb", 32'(io_oeb), 32'hFFFF);
    check("reset_irq", 32'(irq), 32'h0);

    for (int a = 0; a < 64; a++) begin
      rd(a);
      check("map_read", 32'(bus.data_out), (a < 16) ? 32'h00 : 32'hAA);
    end

    wr(0, 8'hFF); wr(1, 8'h5A); wr(7, 8'h0F);
    check("tgl_io_out", 32'(io_out[7:0]), 32'h55);
    check("tgl_io_oeb", 32'(io_oeb[7:0]), 32'h00);
    rd(1);
    check("tgl_port_rd", 32'(bus.data_out), 32'h55);
    wr(7, 8'h00); rd(1);
    check("tgl_zero_noop", 32'(bus.data_out), 32'h55);
    wr(20, 8'hFF); rd(20);
    check("unmapped_wr", 32'(bus.data_out), 32'hAA);
    wr(2, 8'hFF); rd(2);
    check("pin_ro", 32'(bus.data_out), 32'h00);

    wr(11, 8'h01); wr(8, 8'h00);
    sf_out[8] = 1'b1; sf_oe[8] = 1'b1;
    step();
    check("sf_io_out", 32'(io_out[8]), 32'h1);
    check("sf_io_oeb", 32'(io_oeb[8]), 32'h0);
    io_in[8] = 1'b1;
    step();
    check("sf_in8", 32'(sf_in[8]), 32'h1);
    check("sf_in9", 32'(sf_in[9]), 32'h0);

    wr(4, 8'h01); wr(5, 8'h00);
    io_in[0] = 1'b1;
    for (int k = 0; k < SS; k++) step();
    check("rise_early", 32'(irq[0]), 32'h0);
    step();
    check("rise_flag", 32'(irq[0]), 32'h1);
    rd(6);
    check("iflg_rd", 32'(bus.data_out), 32'h01);
    wr(6, 8'h01);
    check("w1c_irq", 32'(irq[0]), 32'h0);
    io_in[0] = 1'b0;
    for (int k = 0; k < SS + 2; k++) step();
    check("fall_ignored", 32'(irq[0]), 32'h0);

    wr(5, 8'h01);
    io_in[0] = 1'b1;
    for (int k = 0; k < SS + 2; k++) step();
    check("rise_ignored", 32'(irq[0]), 32'h0);
    io_in[0] = 1'b0;
    for (int k = 0; k < SS; k++) step();
    wr(6, 8'h01);
    check("set_beats_w1c", 32'(irq[0]), 32'h1);
    rd(6);
    check("set_beats_w1c_rd", 32'(bus.data_out), 32'h01);

    io_in[15:8] = 8'hC3;
    for (int k = 1; k <= SS + 1; k++) begin
      rd(10);
      check("pin_lag", 32'(bus.data_out), (k <= SS) ? 32'h01 : 32'hC3);
    end

    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_dout", 32'(bus.data_out), 32'h00);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_oeb", 32'(io_oeb), 32'hFFFF);
    for (int a = 0; a < 16; a++) begin
      rd(a);
      if (a % 8 != 2) check("rst_regs", 32'(bus.data_out), 32'h00);
    end
    rd(6);
    check("rst_no_flag", 32'(bus.data_out), 32'h00);

    for (int n = 0; n < 600; n++) begin
      rst         = ($urandom_range(0, 79) == 0);
      io_in       = NP8'($urandom);
      sf_out      = NP8'($urandom);
      sf_oe       = NP8'($urandom);
      bus.bus_cyc = 1'($urandom);
      bus.bus_we  = 1'($urandom);
      bus.addr    = AW'($urandom_range(0, 19));
      bus.data_in = 8'($urandom);
      step();
    end
    rst = 1'b0; bus.bus_cyc = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule
